// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with built-in tick prescaler, load check and wrap flag.
// Latency: q, tick, wrap and load_err update one CLOCK_50 edge after the sampled inputs; tc is combinational.
// Backpressure: none; clear and load take effect every cycle, a coinciding count tick is dropped.
module bcd_updown_counter #(
  parameter int                  DIGITS   = 4,
  parameter logic [4*DIGITS-1:0] MAX_BCD  = 16'h9999,
  parameter int                  TICK_DIV = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tick,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int W  = 4 * DIGITS;
  // A divide-by-one prescaler still needs a one-bit register to stay legal.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] ps_q, ps_d;
  logic          tick_q, tick_d;
  logic [W-1:0]  q_q, q_d;
  logic          wrap_q, wrap_d;
  logic          lerr_q, lerr_d;

  logic [W-1:0]  inc_val, dec_val;
  logic          carry, borrow;
  logic          load_ok;
  logic          at_max, at_zero;

  assign at_max  = (q_q == MAX_BCD);
  assign at_zero = (q_q == '0);

  // Prescaler: free-running modulo-TICK_DIV count, tick is registered one cycle after the last state.
  always_comb begin
    ps_d   = ps_q;
    tick_d = 1'b0;
    if (clear) begin
      ps_d   = '0;
      tick_d = 1'b0;
    end else begin
      tick_d = (ps_q == PS_LAST);
      ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + PW'(1);
    end
  end

  // BCD +1 and -1 of the current count; carry and borrow ripple through every digit in one cycle.
  always_comb begin
    inc_val = q_q;
    dec_val = q_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // A load is accepted only if it is well-formed BCD and does not exceed the wrap limit.
  always_comb begin
    load_ok = (load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Count next state: clear beats load beats a qualified tick; wrap/load_err are single-cycle pulses.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      if (load_ok) begin
        q_d = load_val;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (tick_q && en) begin
      if (up) begin
        if (at_max) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = inc_val;
        end
      end else begin
        if (at_zero) begin
          q_d    = MAX_BCD;
          wrap_d = 1'b1;
        end else begin
          q_d = dec_val;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
      q_q    <= '0;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
      q_q    <= q_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

  assign q        = q_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;
  // Terminal count looks ahead at the next enabled tick so a following stage can cascade on it.
  assign tc       = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three configurations driven from shared inputs,
// each compared every cycle against a decimal-arithmetic reference model.
module tb_bcd_updown_counter;

  typedef struct {
    int q;      // count as a plain decimal integer
    int cnt;    // prescaler position
    bit tick;
    bit wrap;
    bit lerr;
  } model_t;

  logic        CLOCK_50;
  logic        reset_n;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic        en;
  logic        up;

  logic [7:0]  qa, qc;
  logic [15:0] qb;
  logic        tick_a, tc_a, wrap_a, lerr_a;
  logic        tick_b, tc_b, wrap_b, lerr_b;
  logic        tick_c, tc_c, wrap_c, lerr_c;

  int tests = 0;
  int fails = 0;
  model_t ma, mb, mc;

  localparam int MAXA = 59;
  localparam int MAXB = 9999;
  localparam int MAXC = 59;

  bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h59), .TICK_DIV(1)) u_a (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val[7:0]), .en(en), .up(up),
    .q(qa), .tick(tick_a), .tc(tc_a), .wrap(wrap_a), .load_err(lerr_a)
  );

  bcd_updown_counter #(.DIGITS(4), .MAX_BCD(16'h9999), .TICK_DIV(1)) u_b (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val), .en(en), .up(up),
    .q(qb), .tick(tick_b), .tc(tc_b), .wrap(wrap_b), .load_err(lerr_b)
  );

  bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h59), .TICK_DIV(5)) u_c (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val[7:0]), .en(en), .up(up),
    .q(qc), .tick(tick_c), .tc(tc_c), .wrap(wrap_c), .load_err(lerr_c)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [31:0] b, input int nd);
    int r;
    r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.q = 0; m.cnt = 0; m.tick = 0; m.wrap = 0; m.lerr = 0;
    return m;
  endfunction

  // One clock edge of the counter, described by its rules on decimal values.
  function automatic model_t model_step(input model_t m, input int nd, input int maxv, input int tdiv,
                                        input bit c, input bit l, input logic [31:0] v,
                                        input bit e, input bit u);
    model_t n;
    logic [31:0] vm;
    bit ok;
    n = m;
    n.wrap = 0;
    n.lerr = 0;
    vm = v & ((32'h1 << (4 * nd)) - 32'h1);
    if (c) begin
      n.cnt = 0;
      n.tick = 0;
    end else begin
      n.tick = (m.cnt == tdiv - 1);
      n.cnt  = (m.cnt == tdiv - 1) ? 0 : m.cnt + 1;
    end
    if (c) begin
      n.q = 0;
    end else if (l) begin
      ok = 1;
      for (int i = 0; i < nd; i++) if (vm[4*i +: 4] > 4'd9) ok = 0;
      if (ok && bcd2int(vm, nd) > maxv) ok = 0;
      if (ok) n.q = bcd2int(vm, nd);
      else    n.lerr = 1;
    end else if (m.tick && e) begin
      if (u) begin
        if (m.q == maxv) begin n.q = 0; n.wrap = 1; end
        else n.q = m.q + 1;
      end else begin
        if (m.q == 0) begin n.q = maxv; n.wrap = 1; end
        else n.q = m.q - 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input string tag, input model_t m, input int maxv, input logic [31:0] q_o,
                           input logic tk, input logic tcv, input logic wr, input logic le);
    bit exp_tc;
    exp_tc = en && ((up && m.q == maxv) || (!up && m.q == 0));
    chk({tag, ".q"},        q_o,         int2bcd(m.q));
    chk({tag, ".tick"},     32'(tk),     32'(m.tick));
    chk({tag, ".wrap"},     32'(wr),     32'(m.wrap));
    chk({tag, ".load_err"}, 32'(le),     32'(m.lerr));
    chk({tag, ".tc"},       32'(tcv),    32'(exp_tc));
  endtask

  task automatic check_all(input string ph);
    check_one({ph, "/a"}, ma, MAXA, 32'(qa), tick_a, tc_a, wrap_a, lerr_a);
    check_one({ph, "/b"}, mb, MAXB, 32'(qb), tick_b, tc_b, wrap_b, lerr_b);
    check_one({ph, "/c"}, mc, MAXC, 32'(qc), tick_c, tc_c, wrap_c, lerr_c);
  endtask

  // Apply inputs, advance one edge, update the models, check 1 time unit later.
  task automatic step(input string ph, input bit c, input bit l, input logic [15:0] v,
                      input bit e, input bit u);
    clear = c; load = l; load_val = v; en = e; up = u;
    @(posedge CLOCK_50);
    ma = model_step(ma, 2, MAXA, 1, c, l, 32'(v), e, u);
    mb = model_step(mb, 4, MAXB, 1, c, l, 32'(v), e, u);
    mc = model_step(mc, 2, MAXC, 5, c, l, 32'(v), e, u);
    #1;
    check_all(ph);
  endtask

  initial begin
    int nwrap;
    int nticks;
    logic [31:0] tmp;
    logic [15:0] rv;
    bit rc, rl, re, ru;

    reset_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
    ma = model_reset(); mb = model_reset(); mc = model_reset();
    #2;
    check_all("reset");

    // Count up through the full 00..59 range and wrap once.
    en = 1'b1; up = 1'b1;
    #10 reset_n = 1'b1;
    nwrap = 0;
    for (int i = 0; i < 62; i++) begin
      step("up_run", 0, 0, 16'h0000, 1, 1);
      if (wrap_a) nwrap++;
    end
    chk("up_run_wrap_count", 32'(nwrap), 32'd1);

    // Down from zero wraps to 59, then borrows across the 50->49 step.
    step("down_clr", 1, 0, 16'h0000, 1, 0);
    for (int i = 0; i < 14; i++) step("down_run", 0, 0, 16'h0000, 1, 0);

    // Malformed and out-of-range loads are rejected; a good load is taken.
    step("ld_7A", 0, 1, 16'h007A, 1, 1);
    chk("ld_7A_err", 32'(lerr_a), 32'd1);
    step("ld_60", 0, 1, 16'h0060, 1, 1);
    chk("ld_60_err", 32'(lerr_a), 32'd1);
    step("ld_42", 0, 1, 16'h0042, 1, 1);
    chk("ld_42_q", 32'(qa), 32'h42);
    chk("ld_42_err", 32'(lerr_a), 32'd0);

    // Four-digit carry ripple and full-scale wrap.
    step("ld_0999", 0, 1, 16'h0999, 1, 1);
    step("inc_0999", 0, 0, 16'h0000, 1, 1);
    chk("carry_1000", 32'(qb), 32'h1000);
    step("ld_9999", 0, 1, 16'h9999, 1, 1);
    step("inc_9999", 0, 0, 16'h0000, 1, 1);
    chk("wrap_0000_q", 32'(qb), 32'h0000);
    chk("wrap_0000_flag", 32'(wrap_b), 32'd1);

    // Divided tick: one pulse per five cycles whether or not counting is enabled.
    nticks = 0;
    for (int i = 0; i < 20; i++) begin
      step("div_en", 0, 0, 16'h0000, 1, 1);
      if (tick_c) nticks++;
    end
    chk("div_tick_count", 32'(nticks), 32'd4);
    for (int i = 0; i < 12; i++) step("div_hold", 0, 0, 16'h0000, 0, 1);
    step("div_clr", 1, 0, 16'h0000, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step("div_restart", 0, 0, 16'h0000, 0, 1);
      chk("div_no_early_tick", 32'(tick_c), 32'd0);
    end
    step("div_restart", 0, 0, 16'h0000, 0, 1);
    chk("div_tick_after_5", 32'(tick_c), 32'd1);

    // Asynchronous reset between edges, then clear beating load.
    step("ld_37", 0, 1, 16'h0037, 1, 1);
    #3 reset_n = 1'b0;
    #1;
    ma = model_reset(); mb = model_reset(); mc = model_reset();
    chk("async_rst_q", 32'(qa), 32'h00);
    chk("async_rst_wrap", 32'(wrap_a), 32'd0);
    check_all("async_rst");
    #2 reset_n = 1'b1;
    step("clr_vs_ld", 1, 1, 16'h0042, 1, 1);
    chk("clr_vs_ld_q", 32'(qa), 32'h00);

    // Randomized mix of counting, direction changes, loads and clears.
    for (int i = 0; i < 500; i++) begin
      rc = ($urandom_range(0, 24) == 0);
      rl = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 3) != 0);
      ru = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 2))
        0: rv = 16'($urandom);
        1: begin tmp = int2bcd($urandom_range(0, 9999)); rv = tmp[15:0]; end
        default: begin tmp = int2bcd($urandom_range(0, 59)); rv = tmp[15:0]; end
      endcase
      step("random", rc, rl, rv, re, ru);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised multi-digit BCD up/down counter. It is the successor of the single-digit decade counter used on the board designs, and it generalises that counter in digit count, wrap limit and count direction. It has its own tick prescaler, so no external divided clock is needed, and every digit runs on CLOCK_50. It drives a row of decodBCD seven-segment decoders, one per nibble of q.

Parameters:
DIGITS, 4, number of BCD digits (1..8); q width is 4*DIGITS.
MAX_BCD, 16'h9999, wrap limit in BCD encoding, width 4*DIGITS; every nibble must be ≤9.
TICK_DIV, 50_000_000, CLOCK_50 cycles per count tick (≥1); 1 gives a tick every cycle, for simulation.

Ports:
CLOCK_50  input  1  system clock; all state changes on its rising edge.
reset_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous clear of counter and prescaler.
load  input  1  synchronous load of load_val.
load_val  input  4*DIGITS  BCD value to load.
en  input  1  count enable, sampled on tick.
up  input  1  direction: 1 = up, 0 = down.
q  output  4*DIGITS  current count in BCD; nibble 0 is the least significant digit.
tick  output  1  one-cycle prescaler pulse.
tc  output  1  terminal count, combinational.
wrap  output  1  registered one-cycle pulse on wrap-around.
load_err  output  1  registered one-cycle pulse when a load is rejected.

Behaviour:
Reset (reset_n = 0, asynchronous):
- q = 0, prescaler = 0, tick = 0, wrap = 0, load_err = 0.
- All outputs hold these values until the first CLOCK_50 edge after reset_n rises.

Prescaler:
- Counts 0..TICK_DIV-1, then returns to 0.
- tick = 1 (registered) in the cycle after the prescaler reaches TICK_DIV-1.
- The prescaler free-runs regardless of en.
- clear forces the prescaler to 0 and tick to 0.

Priority per clock edge (highest first):
- clear: q ← 0.
- load:
  - Accepted if every nibble of load_val is ≤9 and load_val ≤ MAX_BCD (BCD compare is plain unsigned compare). Then q ← load_val.
  - Otherwise q is unchanged and load_err = 1 for one cycle.
- tick & en & up:
  - If q == MAX_BCD: q ← 0 and wrap = 1.
  - Else q ← q + 1 in BCD. A digit of 9 becomes 0 and carries into the next digit; the carry ripples combinationally through all digits in the same cycle.
- tick & en & !up:
  - If q == 0: q ← MAX_BCD and wrap = 1.
  - Else q ← q − 1 in BCD. A digit of 0 becomes 9 and borrows from the next digit.
- Otherwise q holds.

Output and timing rules:
- wrap and load_err are low in every cycle where their condition did not occur.
- clear and load act even when tick = 0 or en = 0.
- A load or clear coinciding with a tick suppresses that count; that tick is lost.
- tc = en & ((up & q == MAX_BCD) | (!up & q == 0)). It is intended for cascading into a further counter's en.
- Changing up between ticks takes effect on the next tick; there is no glitch on q.
- Latency: q updates one CLOCK_50 edge after the qualifying tick/load/clear sample.
- q never holds a nibble above 9 and never exceeds MAX_BCD.

Test Plan:
1. DIGITS=2, MAX_BCD=8'h59, TICK_DIV=1. Release reset_n with en=1, up=1, and run 61 cycles → q steps 00,01..09,10..59,00. wrap is high exactly on the 59→00 step. tc is high while q=59.
2. Same configuration, up=0 starting from q=00 → the next q is 59 with wrap=1, then 58, 57. Step 50→49 checks the borrow.
3. load_val=8'h7A with load=1 → q unchanged, load_err=1 for one cycle. Then load_val=8'h60 (above MAX_BCD) → q unchanged, load_err=1. Then load_val=8'h42 → q=42, load_err=0.
4. DIGITS=4, default MAX_BCD, TICK_DIV=1. Load 0999 and tick up → 1000 (carry ripples through three digits). Load 9999 and tick up → 0000 with wrap=1.
5. TICK_DIV=5 with en=1 → tick is high every 5th cycle and q increments once per 5 cycles. With en=0, tick keeps pulsing and q holds. Pulsing clear mid-period → prescaler restarts, so the next tick comes 5 cycles later.
6. Assert reset_n low asynchronously between clock edges while q=37 → q=00 and wrap=0 immediately. Assert clear and load together → q=00 (clear has priority).
